// File: rtl/camera_init_seq.sv
// Camera register-initialisation sequencer: walks a (register, value) command table and issues one
// AXI-lite write per entry. Define CAMERA_INIT_VERIFY_EN to read back and compare every write.
module camera_init_seq #(
   parameter int NUM_ENTRIES    = 64,
   parameter int DELAY_UNIT     = 83000,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  err_index,
   output logic [7:0]  tbl_addr,
   input  logic [15:0] tbl_data,
   output logic [31:0] axi_awaddr,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [31:0] axi_wdata,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [1:0]  b_response,
   output logic [31:0] axi_araddr,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   input  logic [31:0] axi_rdata,
   input  logic        axi_rvalid,
   output logic        axi_rready
);

   localparam logic [7:0]  LAST_INDEX   = 8'(NUM_ENTRIES - 1);
   localparam logic [31:0] DELAY_MULT   = 32'(DELAY_UNIT);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  REG_DELAY    = 8'hFF;
   localparam logic [7:0]  REG_END      = 8'hFE;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_WR, S_BRESP, S_WAIT,
      S_ADVANCE, S_DONE, S_ERR, S_RD, S_RRESP
   } state_t;

   state_t      state;
   logic [7:0]  index;
   logic [31:0] delay_cnt;
   logic [31:0] timer;
   logic        aw_ok;
   logic        w_ok;
   logic        timed_out;
   logic        unused_rd;

   // A channel counts as finished once its valid has dropped or is handshaking this cycle.
   assign aw_ok     = !axi_awvalid || axi_awready;
   assign w_ok      = !axi_wvalid || axi_wready;
   assign timed_out = (timer == TIMEOUT_LAST);
   assign tbl_addr  = index;

`ifdef CAMERA_INIT_VERIFY_EN
   assign unused_rd = ^axi_rdata[31:9];
`else
   assign axi_araddr  = '0;
   assign axi_arvalid = 1'b0;
   assign axi_rready  = 1'b0;
   assign unused_rd   = ^{axi_arready, axi_rvalid, axi_rdata};
`endif

   // NOTE: every register here uses <= so all branches see the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         index       <= '0;
         delay_cnt   <= '0;
         timer       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_index   <= '0;
         axi_awaddr  <= '0;
         axi_awvalid <= 1'b0;
         axi_wdata   <= '0;
         axi_wvalid  <= 1'b0;
         b_ready     <= 1'b0;
`ifdef CAMERA_INIT_VERIFY_EN
         axi_araddr  <= '0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  error     <= 1'b0;
                  err_index <= '0;
                  index     <= '0;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               if (tbl_data[15:8] == REG_DELAY) begin
                  if (tbl_data[7:0] == 8'd0) begin
                     state <= S_ADVANCE;
                  end else begin
                     delay_cnt <= 32'(tbl_data[7:0]) * DELAY_MULT;
                     state     <= S_WAIT;
                  end
               end else if (tbl_data[15:8] == REG_END) begin
                  state <= S_DONE;
               end else begin
                  axi_awaddr  <= {22'd0, tbl_data[15:8], 2'b00};
                  axi_awvalid <= 1'b1;
                  axi_wdata   <= {24'd0, tbl_data[7:0]};
                  axi_wvalid  <= 1'b1;
                  timer       <= '0;
                  state       <= S_WR;
               end
            end
            S_WR: begin
               if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
               if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
               if (aw_ok && w_ok) begin
                  b_ready <= 1'b1;
                  timer   <= '0;
                  state   <= S_BRESP;
               end else if (timed_out) begin
                  axi_awvalid <= 1'b0;
                  axi_wvalid  <= 1'b0;
                  state       <= S_ERR;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            S_BRESP: begin
               if (b_valid) begin
                  b_ready <= 1'b0;
                  if (b_response != 2'b00) begin
                     state <= S_ERR;
                  end else begin
`ifdef CAMERA_INIT_VERIFY_EN
                     axi_araddr  <= axi_awaddr;
                     axi_arvalid <= 1'b1;
                     timer       <= '0;
                     state       <= S_RD;
`else
                     state <= S_ADVANCE;
`endif
                  end
               end else if (timed_out) begin
                  b_ready <= 1'b0;
                  state   <= S_ERR;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
`ifdef CAMERA_INIT_VERIFY_EN
            S_RD: begin
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  axi_rready  <= 1'b1;
                  timer       <= '0;
                  state       <= S_RRESP;
               end else if (timed_out) begin
                  axi_arvalid <= 1'b0;
                  state       <= S_ERR;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            S_RRESP: begin
               // wdata still holds the value just written; bit 8 flags an I2C NACK.
               if (axi_rvalid) begin
                  axi_rready <= 1'b0;
                  if (axi_rdata[8] || (axi_rdata[7:0] != axi_wdata[7:0])) state <= S_ERR;
                  else                                                  state <= S_ADVANCE;
               end else if (timed_out) begin
                  axi_rready <= 1'b0;
                  state      <= S_ERR;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
`endif
            S_WAIT: begin
               if (delay_cnt == 32'd1) state <= S_ADVANCE;
               else                    delay_cnt <= delay_cnt - 32'd1;
            end
            S_ADVANCE: begin
               if (index == LAST_INDEX) begin
                  state <= S_DONE;
               end else begin
                  index <= index + 8'd1;
                  state <= S_FETCH;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_ERR: begin
               error     <= 1'b1;
               err_index <= index;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_camera_init_seq.sv
// Bench for camera_init_seq: synchronous ROM plus AXI-lite slave model with a write scoreboard.
// Readback cases run only when CAMERA_INIT_VERIFY_EN is defined.
`timescale 1ns/1ps
module tb_camera_init_seq;

   localparam int NUM_ENTRIES    = 8;
   localparam int DELAY_UNIT     = 10;
   localparam int TIMEOUT_CYCLES = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [7:0]  err_index, tbl_addr;
   logic [15:0] tbl_data;
   logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
   logic        b_valid, b_ready;
   logic [1:0]  b_response;
   logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;

   always #5 clk = ~clk;

   camera_init_seq #(
      .NUM_ENTRIES    (NUM_ENTRIES),
      .DELAY_UNIT     (DELAY_UNIT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .err_index   (err_index),
      .tbl_addr    (tbl_addr),
      .tbl_data    (tbl_data),
      .axi_awaddr  (axi_awaddr),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_wdata   (axi_wdata),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_response  (b_response),
      .axi_araddr  (axi_araddr),
      .axi_arvalid (axi_arvalid),
      .axi_arready (axi_arready),
      .axi_rdata   (axi_rdata),
      .axi_rvalid  (axi_rvalid),
      .axi_rready  (axi_rready)
   );

   logic [15:0] rom [256];
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard entries are {awaddr, wdata}.
   logic [63:0] exp_q[$];
   logic [63:0] last_exp;

   int          cfg_aw_delay, cfg_w_delay, cfg_b_delay, cfg_bad_write;
   bit          cfg_b_never, cfg_rdata_force;
   logic [31:0] cfg_rdata;

   int          wr_count, dup_count, early_bready, done_count, both_count, wide_done;
   int          first_aw_cyc, aw_seen_cyc, aw_hs_cyc, b_hs_cyc, last_gap;
   bit          aw_hs, w_hs, aw_seen, scored, cur_bad, b_drop, ar_hs, r_drop, done_q;
   int          aw_cnt, w_cnt, b_cnt;
   logic [31:0] aw_addr_seen, w_data_seen;

   // Slave model: ready/valid decisions made on the falling edge take effect at the next rising edge.
   initial begin
      axi_awready = 0; axi_wready = 0; b_valid = 0; b_response = 0;
      axi_arready = 0; axi_rvalid = 0; axi_rdata = 0;
      forever begin
         @(negedge clk);
         if (done && error) both_count++;
         if (done && done_q) wide_done++;
         if (done) done_count++;
         done_q = done;
         if (rst) begin
            axi_awready = 0; axi_wready = 0; b_valid = 0; b_response = 0;
            axi_arready = 0; axi_rvalid = 0;
            aw_hs = 0; w_hs = 0; aw_seen = 0; scored = 0; b_drop = 0; ar_hs = 0; r_drop = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; first_aw_cyc = -1;
         end else begin
            if (b_ready && !(aw_hs && w_hs)) early_bready++;
            axi_awready = 0;
            if (axi_awvalid) begin
               if (aw_hs) dup_count++;
               else begin
                  if (!aw_seen) begin
                     aw_seen = 1; aw_seen_cyc = cyc; last_gap = cyc - b_hs_cyc;
                     if (first_aw_cyc < 0) first_aw_cyc = cyc;
                  end
                  if (aw_cnt >= cfg_aw_delay) begin
                     axi_awready = 1; aw_hs = 1; aw_addr_seen = axi_awaddr; aw_hs_cyc = cyc;
                  end else aw_cnt++;
               end
            end
            axi_wready = 0;
            if (axi_wvalid) begin
               if (w_hs) dup_count++;
               else if (w_cnt >= cfg_w_delay) begin
                  axi_wready = 1; w_hs = 1; w_data_seen = axi_wdata;
               end else w_cnt++;
            end
            if (aw_hs && w_hs && !scored) begin
               scored = 1; wr_count++; b_cnt = 0;
               cur_bad = (wr_count - 1 == cfg_bad_write);
               if (exp_q.size() == 0) check("write_extra", 1, 0);
               else begin
                  last_exp = exp_q.pop_front();
                  check("write", {aw_addr_seen, w_data_seen}, last_exp);
               end
            end
            if (b_drop) begin
               b_valid = 0; b_drop = 0; aw_hs = 0; w_hs = 0; aw_seen = 0; scored = 0;
               aw_cnt = 0; w_cnt = 0;
            end else begin
               if (!b_valid && scored && !cfg_b_never) begin
                  if (b_cnt >= cfg_b_delay) begin
                     b_valid = 1; b_response = cur_bad ? 2'b10 : 2'b00;
                  end else b_cnt++;
               end
               if (b_valid && b_ready) begin b_drop = 1; b_hs_cyc = cyc; end
            end
            axi_arready = 0;
            if (r_drop) begin
               axi_rvalid = 0; r_drop = 0; ar_hs = 0;
            end else if (axi_arvalid && !ar_hs) begin
               axi_arready = 1; ar_hs = 1;
               check("araddr", axi_araddr, last_exp[63:32]);
            end else if (ar_hs) begin
               axi_rvalid = 1;
               axi_rdata  = cfg_rdata_force ? cfg_rdata : {24'd0, last_exp[7:0]};
               if (axi_rready) r_drop = 1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic set_cfg(input int aw_d, input int w_d, input bit b_never, input int bad);
      cfg_aw_delay = aw_d; cfg_w_delay = w_d; cfg_b_delay = 2;
      cfg_b_never = b_never; cfg_bad_write = bad; cfg_rdata_force = 0; cfg_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; start = 0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      wr_count = 0; b_hs_cyc = 0;
      rst = 0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'hFE00;
   endtask

   // Reference walk of the table: delay entries are skipped, the end marker stops the walk.
   task automatic expect_writes(input int upto);
      logic [7:0] r, v;
      for (int i = 0; i < upto && i < NUM_ENTRIES; i++) begin
         r = rom[i][15:8];
         v = rom[i][7:0];
         if (r == 8'hFE) break;
         if (r != 8'hFF) exp_q.push_back({22'd0, r, 2'b00, 24'd0, v});
      end
   endtask

   int start_cyc;

   task automatic pulse_start();
      @(negedge clk);
      start = 1; start_cyc = cyc;
      @(negedge clk);
      start = 0;
   endtask

   task automatic run_until_end(input int budget, output bit saw_done, output bit saw_err,
                                output int end_cyc);
      saw_done = 0; saw_err = 0; end_cyc = 0;
      for (int i = 0; i < budget; i++) begin
         if (done)  begin saw_done = 1; end_cyc = cyc; break; end
         if (error) begin saw_err = 1;  end_cyc = cyc; break; end
         @(negedge clk);
      end
      if (!saw_done && !saw_err) check("end_timeout", 0, 1);
   endtask

   bit sd, se, any_aw;
   int ec;

   initial begin
      clear_rom();
      set_cfg(0, 0, 0, -1);
      do_reset();
      check("reset_ctrl", {busy, done, error, err_index, tbl_addr}, 0);
      check("reset_axi", {axi_awvalid, axi_wvalid, b_ready, axi_arvalid, axi_rready,
                          axi_awaddr, axi_wdata}, 0);

      // Two writes then an end marker.
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFE00;
      expect_writes(NUM_ENTRIES);
      pulse_start();
      check("busy_after_start", busy, 1);
      check("tbl_addr_first", tbl_addr, 0);
      run_until_end(500, sd, se, ec);
      check("basic_done", {sd, se}, 2'b10);
      check("basic_writes", wr_count, 2);
      check("basic_queue_empty", exp_q.size(), 0);
      check("first_aw_latency_ok", (first_aw_cyc - start_cyc) >= 3, 1);

      // Zero-length and 3-tick delay entries between two writes.
      clear_rom(); do_reset();
      rom[0] = 16'h1001; rom[1] = 16'hFF00; rom[2] = 16'hFF03; rom[3] = 16'h2002;
      expect_writes(NUM_ENTRIES);
      pulse_start();
      run_until_end(500, sd, se, ec);
      check("delay_done", {sd, se}, 2'b10);
      check("delay_writes", wr_count, 2);
      check("delay_gap_ok", (last_gap >= 36) && (last_gap <= 60), 1);

      // W accepted well before AW.
      clear_rom(); set_cfg(6, 0, 0, -1); do_reset();
      rom[0] = 16'h305A;
      expect_writes(NUM_ENTRIES);
      pulse_start();
      run_until_end(500, sd, se, ec);
      check("wfirst_done", {sd, se}, 2'b10);
      check("wfirst_writes", wr_count, 1);
      check("wfirst_queue_empty", exp_q.size(), 0);

      // Third write gets SLVERR; a fresh start clears the error.
      clear_rom(); set_cfg(0, 0, 0, 2); do_reset();
      rom[0] = 16'h0111; rom[1] = 16'h0222; rom[2] = 16'h0333; rom[3] = 16'h0444;
      expect_writes(3);
      pulse_start();
      run_until_end(500, sd, se, ec);
      check("slverr_flag", {sd, se}, 2'b01);
      check("slverr_index", err_index, 2);
      repeat (40) @(negedge clk);
      check("slverr_no_more_writes", wr_count, 3);
      check("slverr_idle", {busy, error, axi_awvalid}, 3'b010);
      cfg_bad_write = -1;
      expect_writes(NUM_ENTRIES);
      pulse_start();
      check("restart_clears_error", {busy, error}, 2'b10);
      run_until_end(500, sd, se, ec);
      check("restart_done", {sd, se}, 2'b10);
      check("restart_writes", wr_count, 7);

      // Full table with no end marker: the walk stops at NUM_ENTRIES.
      clear_rom(); set_cfg(0, 0, 0, -1); do_reset();
      for (int i = 0; i <= NUM_ENTRIES; i++) rom[i] = {8'(8'h40 + i), 8'(i + 1)};
      expect_writes(NUM_ENTRIES);
      pulse_start();
      run_until_end(1000, sd, se, ec);
      check("full_done", {sd, se}, 2'b10);
      check("full_writes", wr_count, NUM_ENTRIES);
      check("full_queue_empty", exp_q.size(), 0);

      // B response never arrives.
      clear_rom(); set_cfg(0, 0, 1, -1); do_reset();
      rom[0] = 16'h0555;
      expect_writes(NUM_ENTRIES);
      pulse_start();
      run_until_end(1000, sd, se, ec);
      check("timeout_flag", {sd, se}, 2'b01);
      check("timeout_index", err_index, 0);
      check("timeout_latency_ok", ((ec - aw_hs_cyc) >= 95) && ((ec - aw_hs_cyc) <= 110), 1);

      // Reset while AW is stalled.
      clear_rom(); set_cfg(100000, 0, 0, -1); do_reset();
      rom[0] = 16'h0666;
      pulse_start();
      any_aw = 0;
      for (int i = 0; i < 20; i++) begin
         if (axi_awvalid) begin any_aw = 1; break; end
         @(negedge clk);
      end
      check("rst_aw_seen", any_aw, 1);
      rst = 1;
      @(negedge clk);
      check("rst_mid_wr", {axi_awvalid, axi_wvalid, b_ready, axi_arvalid, axi_rready,
                           busy, done, error}, 0);
      rst = 0;
      any_aw = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         any_aw |= axi_awvalid;
      end
      check("rst_no_new_aw", any_aw, 0);

`ifdef CAMERA_INIT_VERIFY_EN
      // Readback reports NACK, then a matching readback.
      clear_rom(); set_cfg(0, 0, 0, -1); do_reset();
      cfg_rdata_force = 1; cfg_rdata = 32'h0000017F;
      rom[0] = 16'h1280;
      expect_writes(NUM_ENTRIES);
      pulse_start();
      run_until_end(500, sd, se, ec);
      check("verify_nack_flag", {sd, se}, 2'b01);
      check("verify_nack_index", err_index, 0);
      do_reset();
      cfg_rdata = 32'h00000080;
      expect_writes(NUM_ENTRIES);
      pulse_start();
      run_until_end(500, sd, se, ec);
      check("verify_match_done", {sd, se}, 2'b10);
`endif

      check("no_duplicate_valid", dup_count, 0);
      check("no_early_bready", early_bready, 0);
      check("done_error_exclusive", both_count, 0);
      check("done_one_cycle", wide_done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
